// File: rtl/regfile_32x64.sv
// 32-entry register file: X0..X30 in flops, X31 hardwired to zero.
// Two combinational read ports built from per-bit 32:1 muxes, optional write forwarding.

module mux32to1 (
    input  logic [31:0] i_d,
    input  logic [4:0]  i_sel,
    output logic        o_y
);
    assign o_y = i_d[i_sel];
endmodule

module regfile_32x64 #(
    parameter int WIDTH  = 64,
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    logic [WIDTH-1:0] r_x [31];
    logic [30:0]      w_dec;
    logic [31:0]      w_slice [WIDTH];
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_fwd1;
    logic             w_fwd2;

    // Decoder output for address 31 is never generated, so writes to XZR vanish.
    always_comb begin
        w_dec = '0;
        for (int unsigned r = 0; r < 31; r++) begin
            w_dec[r] = RegWrite && (WriteRegister == 5'(r));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 31; r++) begin
                r_x[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < 31; r++) begin
                if (w_dec[r]) begin
                    r_x[r] <= WriteData;
                end
            end
        end
    end

    // Bit b of every register feeds mux b; slot 31 stays tied to zero.
    always_comb begin
        w_slice = '{default: '0};
        for (int unsigned b = 0; b < WIDTH; b++) begin
            for (int unsigned r = 0; r < 31; r++) begin
                w_slice[b][r] = r_x[r][b];
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux32to1 u_mux1 (
            .i_d   (w_slice[b]),
            .i_sel (ReadRegister1),
            .o_y   (w_rd1[b])
        );
        mux32to1 u_mux2 (
            .i_d   (w_slice[b]),
            .i_sel (ReadRegister2),
            .o_y   (w_rd2[b])
        );
    end

    // Forwarding is suppressed during reset so reads stay zero while clearing.
    assign w_fwd1 = (BYPASS != 0) && RegWrite && !reset &&
                    (WriteRegister == ReadRegister1) && (ReadRegister1 != 5'd31);
    assign w_fwd2 = (BYPASS != 0) && RegWrite && !reset &&
                    (WriteRegister == ReadRegister2) && (ReadRegister2 != 5'd31);

    assign ReadData1 = w_fwd1 ? WriteData : w_rd1;
    assign ReadData2 = w_fwd2 ? WriteData : w_rd2;
endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- 32-entry general-purpose register file; the storage stage feeding the CPU's 32:1 bit-slice read multiplexers.
- Holds WIDTH-bit registers X0..X31, with one synchronous write port and two combinational read ports.
- Each read port is built as WIDTH instances of the existing 32:1 single-bit mux. Bit i of all 32 registers feeds mux instance i; the read address drives sel.
- X31 is the hardwired zero register (XZR).

Parameters:
- WIDTH, 64, data width of each register and of all data ports.
- BYPASS, 0, 1 = write-to-read forwarding in the same cycle; 0 = read returns the stored value.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers immediately.
- RegWrite  input  1  write enable, sampled at rising clk.
- WriteRegister  input  5  write address.
- WriteData  input  WIDTH  write data.
- ReadRegister1  input  5  read port 1 address.
- ReadRegister2  input  5  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.

Behaviour:
- Storage: 31 WIDTH-bit registers, X0..X30, built from D flip-flops with async reset. X31 has no storage; its mux inputs are tied to 0.
- Reset:
  - While reset=1, X0..X30 = 0 asynchronously, regardless of clk.
  - ReadData1 and ReadData2 therefore read 0 for any address.
  - Writes are blocked while reset=1. If reset is high at a clock edge, no write occurs.
- Write decode:
  - 5:32 one-hot decoder on WriteRegister, gated by RegWrite.
  - At rising clk with RegWrite=1 and reset=0: X[WriteRegister] <= WriteData.
  - All other registers hold.
  - RegWrite=0 means no register changes.
- X31 rules:
  - A write to address 31 is discarded.
  - A read of address 31 always returns 0, including when BYPASS=1 and a write to 31 is pending.
- Read ports:
  - Purely combinational; no clock latency.
  - ReadDataN[i] = mux32(bit i of X0..X31, sel=ReadRegisterN).
  - An address change propagates within the same cycle.
  - Both ports may read the same address simultaneously, with identical results.
- Write timing, BYPASS=0: a read of the address being written shows the old value until the rising edge, and the new value afterwards.
- Write timing, BYPASS=1: if RegWrite=1, WriteRegister==ReadRegisterN, and the address is not 31, then ReadDataN = WriteData combinationally in the same cycle. The forwarding compare is per port and independent.
- Write and read of different addresses in the same cycle do not interact.
- Reset mid-operation: asserting reset between edges clears all contents at once. The first write after reset deasserts takes effect at the first rising edge with reset=0.
- No X propagation: after reset, every read address yields a defined value.

Test Plan:
- Reset clear: write 0xDEAD_BEEF_0000_0001 to X5, pulse reset mid-cycle -> ReadData1 reads X5 = 0 immediately, before the next clk edge.
- Write/read all:
  - For n=0..30, write n*0x0101_0101_0101_0101 at consecutive edges.
  - Then sweep ReadRegister1 = 0..31 and ReadRegister2 = 31..0.
  - Expected: each port returns the written pattern for X0..X30, and 0 for X31.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=all-ones, one edge -> ReadData1(31) = 0; no other register is modified (spot-check X0 and X30 unchanged).
- Write-enable gating: RegWrite=0 with WriteRegister=7, WriteData=0x1234 over 3 edges -> X7 keeps its prior value 0x0707_0707_0707_0707.
- Same-cycle read-during-write:
  - X9 holds 0xAAAA..., drive a write of 0x5555... to X9 with ReadRegister1=9.
  - BYPASS=0: ReadData1 = 0xAAAA... before the edge and 0x5555... after it.
  - BYPASS=1: ReadData1 = 0x5555... before the edge.
- Reset vs write collision: reset=1 coincident with a clk edge while RegWrite=1, WriteRegister=3, WriteData=0xFF -> X3 = 0 after reset deasserts; the next edge with reset=0 writes 0xFF.
